// File: rtl/seq_det_word_ctrl.sv
// Word-to-bit sequencer for a shared serial Mealy detector: shifts each word MSB first,
// counts the detector's match pulses and returns a saturating per-word result.
module seq_det_word_ctrl #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_clear,
    output logic              det_rst,
    output logic              det_in,
    input  logic              det_out,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  m_count,
    output logic              m_hit,
    output logic              busy
);

    localparam int unsigned IDX_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0] IdxLast = IDX_W'(WORD_W - 1);
    localparam logic [IDX_W-1:0] IdxOne  = IDX_W'(1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax  = '1;

    typedef enum logic [1:0] {StIdle, StClr, StShift, StDone} state_e;

    state_e            state_q;
    logic [WORD_W-1:0] shreg_q;
    logic [IDX_W-1:0]  idx_q;
    logic [CNT_W-1:0]  count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            shreg_q <= '0;
            idx_q   <= '0;
            count_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (s_valid) begin
                        shreg_q <= s_data;
                        idx_q   <= IdxLast;
                        count_q <= '0;
                        state_q <= s_clear ? StClr : StShift;
                    end
                end
                StClr: state_q <= StShift;
                StShift: begin
                    // det_out is Mealy on the bit currently driven, so it scores this bit
                    if (det_out && (count_q != CntMax)) begin
                        count_q <= count_q + CntOne;
                    end
                    shreg_q <= {shreg_q[WORD_W-2:0], 1'b0};
                    idx_q   <= idx_q - IdxOne;
                    if (idx_q == '0) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (m_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Reset passes straight through so the detector restarts in the same cycle as this block
    assign det_rst = rst | (state_q == StClr);
    assign det_in  = (state_q == StShift) & shreg_q[WORD_W-1];
    assign s_ready = (state_q == StIdle);
    assign m_valid = (state_q == StDone);
    assign busy    = (state_q != StIdle);
    assign m_count = count_q;
    assign m_hit   = (count_q != '0);

endmodule

// File: tb/tb_seq_det_word_ctrl.sv
// Directed bench for seq_det_word_ctrl with an overlapping "11" Mealy detector model;
// a second instance with CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_seq_det_word_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_clear;
    logic       m_ready;

    logic       s_ready, det_rst, det_in, det_out, m_valid, m_hit, busy;
    logic [3:0] m_count;
    logic       s_ready2, det_rst2, det_in2, det_out2, m_valid2, m_hit2, busy2;
    logic [1:0] m_count2;

    int nvec = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    seq_det_word_ctrl #(.WORD_W(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_clear(s_clear), .det_rst(det_rst), .det_in(det_in), .det_out(det_out),
        .m_valid(m_valid), .m_ready(m_ready), .m_count(m_count), .m_hit(m_hit), .busy(busy)
    );

    seq_det_word_ctrl #(.WORD_W(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data),
        .s_clear(s_clear), .det_rst(det_rst2), .det_in(det_in2), .det_out(det_out2),
        .m_valid(m_valid2), .m_ready(m_ready), .m_count(m_count2), .m_hit(m_hit2),
        .busy(busy2)
    );

    // Detector models advance only while a bit is being presented, so state spans words
    logic prev1, prev2;
    assign det_out  = det_in & prev1;
    assign det_out2 = det_in2 & prev2;

    always @(posedge clk) begin
        if (det_rst) prev1 <= 1'b0;
        else if (busy && !m_valid) prev1 <= det_in;
        if (det_rst2) prev2 <= 1'b0;
        else if (busy2 && !m_valid2) prev2 <= det_in2;
    end

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Offer one word, then follow it until m_valid (bounded); record the bits sent
    task automatic do_word(input logic [7:0] d, input logic c, output int lat,
                           output logic [7:0] bits, output int nrst);
        @(negedge clk);
        check("s_ready_before_word", int'(s_ready), 1);
        s_valid = 1'b1;
        s_data  = d;
        s_clear = c;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_data  = ~d;
        s_clear = ~c;
        lat  = 0;
        bits = '0;
        nrst = 0;
        while (!m_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            if (det_rst) nrst++;
            else if (busy && !m_valid) bits = {bits[6:0], det_in};
        end
        check("m_valid_timeout", int'(m_valid), 1);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       clear;
        int         cnt;
        int         cnt2;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int lat, nrst;
        logic [7:0] bits;

        vecs[0] = '{8'hB6, 1'b1, 2, 2};
        vecs[1] = '{8'h01, 1'b1, 0, 0};
        vecs[2] = '{8'h80, 1'b0, 1, 1};   // match straddles the word boundary
        vecs[3] = '{8'h01, 1'b1, 0, 0};
        vecs[4] = '{8'h80, 1'b1, 0, 0};
        vecs[5] = '{8'hFF, 1'b1, 7, 3};   // narrow counter saturates
        vecs[6] = '{8'h00, 1'b0, 0, 0};
        vecs[7] = '{8'hAA, 1'b1, 0, 0};
        vecs[8] = '{8'h7F, 1'b0, 6, 3};

        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_clear = 1'b0; m_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", int'(s_ready), 1);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_det_rst", int'(det_rst), 1);
        check("rst_det_in", int'(det_in), 0);
        check("rst_m_count", int'(m_count), 0);
        check("rst_m_hit", int'(m_hit), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_det_rst", int'(det_rst), 0);

        for (int i = 0; i < 9; i++) begin
            do_word(vecs[i].data, vecs[i].clear, lat, bits, nrst);
            check($sformatf("v%0d_latency", i), lat, vecs[i].clear ? 10 : 9);
            check($sformatf("v%0d_bits", i), int'(bits), int'(vecs[i].data));
            check($sformatf("v%0d_det_rst_cycles", i), nrst, vecs[i].clear ? 1 : 0);
            check($sformatf("v%0d_m_count", i), int'(m_count), vecs[i].cnt);
            check($sformatf("v%0d_m_hit", i), int'(m_hit), vecs[i].cnt != 0 ? 1 : 0);
            check($sformatf("v%0d_m_count_w2", i), int'(m_count2), vecs[i].cnt2);
            check($sformatf("v%0d_m_hit_w2", i), int'(m_hit2), vecs[i].cnt2 != 0 ? 1 : 0);
            @(negedge clk);
            check($sformatf("v%0d_idle_after", i), int'(s_ready), 1);
            check($sformatf("v%0d_m_valid_drop", i), int'(m_valid), 0);
        end

        // Backpressure: result holds, s_valid pulse ignored
        m_ready = 1'b0;
        do_word(8'hB6, 1'b1, lat, bits, nrst);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_m_valid", int'(m_valid), 1);
            check("bp_m_count", int'(m_count), 2);
            check("bp_s_ready", int'(s_ready), 0);
            s_valid = (k == 2);
            s_data  = 8'hFF;
            s_clear = 1'b1;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        check("bp_release_s_ready", int'(s_ready), 1);
        check("bp_release_busy", int'(busy), 0);
        check("bp_release_m_count", int'(m_count), 2);
        @(negedge clk);
        check("bp_ignored_pulse_busy", int'(busy), 0);

        // Reset mid-word: abandoned, no result
        @(negedge clk);
        s_valid = 1'b1; s_data = 8'hFF; s_clear = 1'b0;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_shift_busy", int'(busy), 1);
        check("mid_shift_det_in", int'(det_in), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_det_rst", int'(det_rst), 1);
        @(negedge clk);
        rst = 1'b0;
        check("post_rst_s_ready", int'(s_ready), 1);
        check("post_rst_det_in", int'(det_in), 0);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_m_count", int'(m_count), 0);
        begin
            int seen = 0;
            for (int k = 0; k < 15; k++) begin
                @(negedge clk);
                if (m_valid || busy) seen++;
            end
            check("post_rst_no_result", seen, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
